pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
Sequences reset of the clk200 PLLE2_BASE from the free-running 200 MHz sysclk domain.
- Debounces the SW5 push-button.
- Drives the PLL RST with a guaranteed minimum pulse width, then waits for LOCKED with a timeout and bounded retries.
- Releases a downstream active-low user reset only after lock has been stable for a hold time.
- Sits between the IBUFDS/sysclk, the PLL and the clk200 user logic; user_rst_n is re-synchronized into clk200 by the consumer.

Parameters:
- DEBOUNCE_CYCLES, 2_000_000, consecutive stable sysclk cycles (10 ms) required to accept a new button level.
- PLL_RST_CYCLES, 200, pll_rst high time per attempt (1 us).
- LOCK_TIMEOUT_CYCLES, 20_000, maximum wait for lock per attempt (100 us).
- MAX_RETRIES, 3, failed attempts before FAULT; legal range 1..7.
- RST_HOLD_CYCLES, 16, cycles of continuous lock before user_rst_n is released.

Ports:
- sysclk, in, 1, 200 MHz reference clock; all logic is in this domain.
- rst_n, in, 1, asynchronous active-low reset.
- btn_in, in, 1, raw GPIO_SW_N level, asynchronous; high when pressed.
- restart_req, in, 1, synchronous single-cycle software restart request.
- pll_locked, in, 1, PLL LOCKED, asynchronous.
- pll_rst, out, 1, to PLL RST.
- user_rst_n, out, 1, active-low reset for clk200 user logic.
- seq_ready, out, 1, high in RUN.
- seq_fault, out, 1, high in FAULT.
- retry_cnt, out, 3, number of failed attempts in the current sequence.
- lock_loss_cnt, out, 8, saturating count of lock losses seen in RUN.

Behaviour:
- Reset values while rst_n is low:
  - pll_rst=1, user_rst_n=0, seq_ready=0, seq_fault=0.
  - retry_cnt=0, lock_loss_cnt=0.
  - state=RST_PLL with the phase counter at 0.
- Input conditioning:
  - btn_in and pll_locked each pass through a 2-flop synchronizer, adding 2 cycles of latency.
  - btn_sync then feeds a debouncer. The debounced level changes only after btn_sync differs from it for DEBOUNCE_CYCLES consecutive cycles; the counter clears on any agreement.
  - btn_evt is a 1-cycle pulse on the debounced rising edge (press). Release events are ignored.
- restart = btn_evt OR restart_req. It has the highest priority in every state:
  - next state RST_PLL, phase counter cleared, retry_cnt cleared.
  - lock_loss_cnt is preserved.
- States and per-state behaviour (a single phase counter is shared and cleared on every state entry):
  - RST_PLL:
    - Outputs: pll_rst=1, user_rst_n=0.
    - After PLL_RST_CYCLES cycles, go to WAIT_LOCK.
  - WAIT_LOCK:
    - Output: pll_rst=0.
    - locked_sync=1 → HOLD.
    - Counter reaches LOCK_TIMEOUT_CYCLES → retry_cnt+1. Then, if the new value equals MAX_RETRIES, go to FAULT; otherwise go to RST_PLL.
  - HOLD:
    - locked_sync high for RST_HOLD_CYCLES consecutive cycles → RUN.
    - locked_sync drops → treated as a failed attempt, with the same retry/FAULT rule as a timeout.
  - RUN:
    - Outputs: user_rst_n=1, seq_ready=1, retry_cnt retained.
    - locked_sync=0 → lock_loss_cnt+1 (saturating at 255), retry_cnt cleared, go to RST_PLL.
    - user_rst_n falls in the same cycle the state leaves RUN.
  - FAULT:
    - Outputs: pll_rst=1, user_rst_n=0, seq_fault=1.
    - Leaves only on restart.
- All outputs are registered, i.e. a function of the current state.
- Latency in the nominal case, from rst_n deassertion to seq_ready: PLL_RST_CYCLES + (lock latency + 2) + RST_HOLD_CYCLES + 1.
- Simultaneous events: restart beats timeout, lock-loss and lock. A timeout and lock arriving in the same cycle count as lock.
- Asynchronous reset asserted mid-sequence returns all outputs to their reset values immediately.

Decomposition:
- Package zc702_pl_mvp_pkg holds:
  - enum seq_state_t {RST_PLL, WAIT_LOCK, HOLD, RUN, FAULT};
  - default timing constants derived from SYSCLK_PERIOD_NS = 5.
- Counter widths are $clog2 of the largest of PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES and RST_HOLD_CYCLES.
- One sub-module, sync_debounce, covers the 2-flop synchronizer, the debounce counter and the press pulse; it is instantiated for btn_in.
- pll_locked uses a bare 2-flop synchronizer inside the top module.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2, RST_HOLD_CYCLES=4.
1. Nominal: rst_n release; pll_locked rises 10 cycles after pll_rst falls → pll_rst high exactly 4 cycles; seq_ready and user_rst_n rise 10+2+4+1 cycles after pll_rst falls; retry_cnt=0.
2. Timeout/fault: pll_locked held 0 → two attempts each with pll_rst high 4 cycles and a 32-cycle wait; retry_cnt goes 1 then 2; seq_fault=1, pll_rst=1. A later restart_req pulse → retry_cnt=0 and a new RST_PLL.
3. Bounce: btn_in toggles every 3 cycles for 40 cycles, then holds 1 for 10 cycles while in RUN → no restart during bouncing; exactly one RST_PLL entry, 8 cycles after the stable level reaches btn_sync.
4. Lock loss in RUN: pll_locked drops for 1 cycle → user_rst_n=0 and seq_ready=0 two cycles later; lock_loss_cnt=1; full resequence. After 300 losses, lock_loss_cnt=255.
5. HOLD glitch: pll_locked 1 for 2 cycles, 0 for 1 cycle, then 1 → retry_cnt=1, RST_PLL re-entered, then RUN.
6. Priority: restart_req asserted in the same cycle the WAIT_LOCK counter hits 32 → next state RST_PLL with retry_cnt=0, not incremented.

Source files
------------

// File: rtl/zc702_pl_mvp_pkg.sv
// ---------------------------------------------------------------------------
// zc702_pl_mvp_pkg
// Shared types and default timing for the clk200 PLL reset sequencer.
// All defaults are expressed in 200 MHz sysclk cycles (5 ns period).
// ---------------------------------------------------------------------------
package zc702_pl_mvp_pkg;

  localparam int unsigned SYSCLK_PERIOD_NS = 5;

  // 10 ms button debounce
  localparam int unsigned DEBOUNCE_CYCLES_DEF     = 10_000_000 / SYSCLK_PERIOD_NS;
  // 1 us PLL reset pulse
  localparam int unsigned PLL_RST_CYCLES_DEF      = 1_000 / SYSCLK_PERIOD_NS;
  // 100 us lock timeout per attempt
  localparam int unsigned LOCK_TIMEOUT_CYCLES_DEF = 100_000 / SYSCLK_PERIOD_NS;
  localparam int unsigned MAX_RETRIES_DEF         = 3;
  localparam int unsigned RST_HOLD_CYCLES_DEF     = 16;

  typedef enum logic [2:0] {
    RST_PLL,
    WAIT_LOCK,
    HOLD,
    RUN,
    FAULT
  } seq_state_t;

  // Width of the shared phase counter: enough to reach the largest terminal
  // count (the counter only ever needs to hold N-1).
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer_if
// Bundles the sequencer's button/restart inputs, PLL handshake and status.
//   btn_in        raw push-button level (async, high = pressed)
//   restart_req   single-cycle software restart (sysclk domain)
//   pll_locked    PLL LOCKED (async)
//   pll_rst       PLL RST
//   user_rst_n    active-low reset for clk200 user logic
//   seq_ready     sequencer in RUN
//   seq_fault     sequencer in FAULT
//   retry_cnt     failed attempts in the current sequence
//   lock_loss_cnt saturating count of lock losses seen in RUN
// master: the sequencer; slave: the surrounding board logic / PLL.
// ---------------------------------------------------------------------------
interface pll_reset_sequencer_if;

  logic       btn_in;
  logic       restart_req;
  logic       pll_locked;
  logic       pll_rst;
  logic       user_rst_n;
  logic       seq_ready;
  logic       seq_fault;
  logic [2:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  modport master (
    input  btn_in, restart_req, pll_locked,
    output pll_rst, user_rst_n, seq_ready, seq_fault, retry_cnt, lock_loss_cnt
  );

  modport slave (
    output btn_in, restart_req, pll_locked,
    input  pll_rst, user_rst_n, seq_ready, seq_fault, retry_cnt, lock_loss_cnt
  );

endinterface

// File: rtl/pll_reset_sequencer_sync_debounce.sv
// ---------------------------------------------------------------------------
// sync_debounce
// 2-flop synchronizer, debounce counter and press detector for one button.
//   sysclk   sampling clock
//   rst_n    asynchronous active-low reset
//   async_in raw asynchronous level
//   press    1-cycle pulse when the debounced level rises
// ---------------------------------------------------------------------------
module sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic async_in,
  output logic press
);

  localparam int unsigned DEB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q,  meta_d;
  logic             sync_q,  sync_d;
  logic             level_q, level_d;
  logic [DEB_W-1:0] run_q,   run_d;

  always_comb begin
    meta_d  = async_in;
    sync_d  = meta_q;
    level_d = level_q;
    run_d   = '0;
    if (sync_q != level_q) begin
      if (run_q == DEB_LAST) begin
        level_d = sync_q;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  // Taken from the next level so the restart lands on the same edge the
  // debounced level is accepted, not one cycle later.
  assign press = level_d & ~level_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      run_q   <= '0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
// Sequences the clk200 PLLE2_BASE reset from the free-running sysclk domain:
// pulses PLL RST, waits for LOCKED with timeout and bounded retries, and
// releases user_rst_n once lock has been stable for a hold time.
//   sysclk  200 MHz reference clock (all logic)
//   rst_n   asynchronous active-low reset
//   bus     pll_reset_sequencer_if.master (button, restart, PLL, status)
// ---------------------------------------------------------------------------
module pll_reset_sequencer
  import zc702_pl_mvp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned PLL_RST_CYCLES      = PLL_RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
  parameter int unsigned MAX_RETRIES         = MAX_RETRIES_DEF,
  parameter int unsigned RST_HOLD_CYCLES     = RST_HOLD_CYCLES_DEF
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  pll_reset_sequencer_if.master bus
);

  localparam int unsigned CNT_W =
    cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, RST_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRIES);

  logic             lk_meta_q, lk_meta_d;
  logic             lk_sync_q, lk_sync_d;
  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             pll_rst_q, pll_rst_d;
  logic             user_rst_n_q, user_rst_n_d;
  logic             seq_ready_q, seq_ready_d;
  logic             seq_fault_q, seq_fault_d;

  logic btn_evt;
  logic restart;
  logic attempt_failed;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .async_in(bus.btn_in),
    .press   (btn_evt)
  );

  assign restart = btn_evt | bus.restart_req;

  always_comb begin
    lk_meta_d      = bus.pll_locked;
    lk_sync_d      = lk_meta_q;
    state_d        = state_q;
    retry_d        = retry_q;
    loss_d         = loss_q;
    attempt_failed = 1'b0;

    case (state_q)
      RST_PLL: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock wins over a coincident timeout.
        if (lk_sync_q)              state_d = HOLD;
        else if (cnt_q == TO_LAST)  attempt_failed = 1'b1;
      end
      HOLD: begin
        if (!lk_sync_q)               attempt_failed = 1'b1;
        else if (cnt_q == HOLD_LAST)  state_d = RUN;
      end
      RUN: begin
        if (!lk_sync_q) begin
          state_d = RST_PLL;
          retry_d = '0;
          if (loss_q != '1) loss_d = loss_q + 8'd1;
        end
      end
      FAULT: ;
      default: state_d = RST_PLL;
    endcase

    if (attempt_failed) begin
      retry_d = retry_q + 3'd1;
      state_d = (retry_d == RETRY_MAX) ? FAULT : RST_PLL;
    end

    // Restart overrides everything above, including a lock-loss increment.
    if (restart) begin
      state_d = RST_PLL;
      retry_d = '0;
      loss_d  = loss_q;
    end

    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == RUN) || (state_q == FAULT)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Outputs decoded from the next state so they flip on the same edge as
    // the state register.
    pll_rst_d    = (state_d == RST_PLL) || (state_d == FAULT);
    user_rst_n_d = (state_d == RUN);
    seq_ready_d  = (state_d == RUN);
    seq_fault_d  = (state_d == FAULT);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta_q    <= 1'b0;
      lk_sync_q    <= 1'b0;
      state_q      <= RST_PLL;
      cnt_q        <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      pll_rst_q    <= 1'b1;
      user_rst_n_q <= 1'b0;
      seq_ready_q  <= 1'b0;
      seq_fault_q  <= 1'b0;
    end else begin
      lk_meta_q    <= lk_meta_d;
      lk_sync_q    <= lk_sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      pll_rst_q    <= pll_rst_d;
      user_rst_n_q <= user_rst_n_d;
      seq_ready_q  <= seq_ready_d;
      seq_fault_q  <= seq_fault_d;
    end
  end

  assign bus.pll_rst       = pll_rst_q;
  assign bus.user_rst_n    = user_rst_n_q;
  assign bus.seq_ready     = seq_ready_q;
  assign bus.seq_fault     = seq_fault_q;
  assign bus.retry_cnt     = retry_q;
  assign bus.lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
// Directed scenarios plus randomized stimulus, every cycle compared against a
// cycle-level behavioural model of the sequencing rules.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  localparam int DEB   = 8;
  localparam int RSTC  = 4;
  localparam int TO    = 32;
  localparam int MAXR  = 2;
  localparam int HOLDC = 4;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 sysclk = ~sysclk;

  pll_reset_sequencer_if bus();

  pll_reset_sequencer #(
    .DEBOUNCE_CYCLES    (DEB),
    .PLL_RST_CYCLES     (RSTC),
    .LOCK_TIMEOUT_CYCLES(TO),
    .MAX_RETRIES        (MAXR),
    .RST_HOLD_CYCLES    (HOLDC)
  ) dut (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_RESETTING, M_WAITING, M_HOLDING, M_RUNNING, M_FAULTED} mode_t;
  mode_t m_mode;
  int    m_elapsed;   // cycles already completed in the current mode
  int    m_tries;
  int    m_losses;
  bit    lk_a, lk_b, bt_a, bt_b;
  bit    deb;
  int    deb_run;

  task automatic model_reset();
    m_mode = M_RESETTING; m_elapsed = 0; m_tries = 0; m_losses = 0;
    lk_a = 0; lk_b = 0; bt_a = 0; bt_b = 0; deb = 0; deb_run = 0;
  endtask

  task automatic model_step();
    bit    lk_seen, bt_seen, press, restart, failed;
    mode_t nxt;
    lk_seen = lk_b; bt_seen = bt_b;
    lk_b = lk_a; lk_a = bus.pll_locked;
    bt_b = bt_a; bt_a = bus.btn_in;
    press = 0;
    if (bt_seen != deb) begin
      deb_run++;
      if (deb_run == DEB) begin
        press = bt_seen;
        deb = bt_seen;
        deb_run = 0;
      end
    end else begin
      deb_run = 0;
    end
    restart = press || bus.restart_req;
    nxt = m_mode;
    failed = 0;
    if (restart) begin
      nxt = M_RESETTING;
      m_tries = 0;
    end else begin
      case (m_mode)
        M_RESETTING: if (m_elapsed + 1 >= RSTC) nxt = M_WAITING;
        M_WAITING:   if (lk_seen) nxt = M_HOLDING;
                     else if (m_elapsed + 1 >= TO) failed = 1;
        M_HOLDING:   if (!lk_seen) failed = 1;
                     else if (m_elapsed + 1 >= HOLDC) nxt = M_RUNNING;
        M_RUNNING:   if (!lk_seen) begin
                       nxt = M_RESETTING;
                       m_tries = 0;
                       m_losses = (m_losses >= 255) ? 255 : m_losses + 1;
                     end
        default: ;
      endcase
      if (failed) begin
        m_tries++;
        nxt = (m_tries >= MAXR) ? M_FAULTED : M_RESETTING;
      end
    end
    m_elapsed = (restart || nxt != m_mode) ? 0 : m_elapsed + 1;
    m_mode = nxt;
  endtask

  task automatic compare_all();
    check("pll_rst",       bus.pll_rst,       (m_mode == M_RESETTING) || (m_mode == M_FAULTED));
    check("user_rst_n",    bus.user_rst_n,    m_mode == M_RUNNING);
    check("seq_ready",     bus.seq_ready,     m_mode == M_RUNNING);
    check("seq_fault",     bus.seq_fault,     m_mode == M_FAULTED);
    check("retry_cnt",     bus.retry_cnt,     m_tries);
    check("lock_loss_cnt", bus.lock_loss_cnt, m_losses);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge sysclk);
    if (rst_n) model_step();
    else       model_reset();
    @(negedge sysclk);
    compare_all();
  endtask

  function automatic logic sig_of(input int sel);
    case (sel)
      0:       return bus.pll_rst;
      1:       return bus.seq_ready;
      default: return bus.seq_fault;
    endcase
  endfunction

  // Ticks until the selected output equals val; n = ticks taken, -1 on expiry.
  task automatic run_until(input int sel, input logic val, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (sig_of(sel) === val) begin
        n = i;
        break;
      end
    end
  endtask

  int n, entries, first, drops, bad, lk_left, bt_left;
  logic prev_rst;

  initial begin
    bus.btn_in = 0; bus.restart_req = 0; bus.pll_locked = 0;
    model_reset();
    repeat (3) tick();
    check("reset_pll_rst",    bus.pll_rst, 1);
    check("reset_user_rst_n", bus.user_rst_n, 0);
    check("reset_seq_ready",  bus.seq_ready, 0);
    check("reset_seq_fault",  bus.seq_fault, 0);
    check("reset_retry",      bus.retry_cnt, 0);
    check("reset_losses",     bus.lock_loss_cnt, 0);

    // Nominal bring-up: lock 10 cycles after pll_rst falls.
    rst_n = 1;
    run_until(0, 0, 50, n);
    check("nominal_rst_width", n, RSTC);
    repeat (10) tick();
    bus.pll_locked = 1;
    run_until(1, 1, 50, n);
    check("nominal_ready_latency", 10 + n, 10 + 2 + HOLDC + 1);
    check("nominal_user_rst_n", bus.user_rst_n, 1);
    check("nominal_retry", bus.retry_cnt, 0);

    // Bouncing button in RUN, then a stable press.
    drops = 0;
    for (int t = 0; t < 40; t++) begin
      bus.btn_in = ((t / 3) % 2 == 0);
      tick();
      if (bus.seq_ready !== 1'b1) drops++;
    end
    check("bounce_no_restart", drops, 0);
    bus.btn_in = 1; entries = 0; first = -1; prev_rst = bus.pll_rst;
    for (int t = 1; t <= 40; t++) begin
      if (t == 11) bus.btn_in = 0;
      tick();
      if (bus.pll_rst === 1'b1 && prev_rst === 1'b0) begin
        entries++;
        if (first < 0) first = t;
      end
      prev_rst = bus.pll_rst;
    end
    check("bounce_entries", entries, 1);
    check("bounce_entry_delay", first, 2 + DEB);
    check("bounce_back_in_run", bus.seq_ready, 1);

    // Timeouts into FAULT, then software restart.
    bus.pll_locked = 0; bus.restart_req = 1;
    tick();
    bus.restart_req = 0;
    check("fault_restart_pll_rst", bus.pll_rst, 1);
    run_until(0, 0, 50, n);  check("fault_rst_width1", n, RSTC);
    run_until(0, 1, 100, n); check("fault_wait1", n, TO);
    check("fault_retry1", bus.retry_cnt, 1);
    run_until(0, 0, 50, n);  check("fault_rst_width2", n, RSTC);
    run_until(2, 1, 100, n); check("fault_wait2", n, TO);
    check("fault_retry2", bus.retry_cnt, MAXR);
    check("fault_pll_rst", bus.pll_rst, 1);
    repeat (20) tick();
    check("fault_sticky", bus.seq_fault, 1);
    bus.restart_req = 1;
    tick();
    bus.restart_req = 0;
    check("fault_clear_retry", bus.retry_cnt, 0);
    check("fault_clear_flag", bus.seq_fault, 0);
    check("fault_clear_pll_rst", bus.pll_rst, 1);

    // Restart coinciding with the lock timeout.
    run_until(0, 0, 50, n);
    repeat (TO - 1) tick();
    check("prio_still_waiting", bus.pll_rst, 0);
    bus.restart_req = 1;
    tick();
    bus.restart_req = 0;
    check("prio_retry", bus.retry_cnt, 0);
    check("prio_pll_rst", bus.pll_rst, 1);
    run_until(0, 0, 50, n);
    check("prio_rst_width", n, RSTC);

    // Lock glitch during HOLD.
    bus.pll_locked = 1; tick(); tick();
    bus.pll_locked = 0; tick();
    bus.pll_locked = 1;
    run_until(0, 1, 50, n);
    check("glitch_reenter", n > 0, 1);
    check("glitch_retry", bus.retry_cnt, 1);
    run_until(1, 1, 100, n);
    check("glitch_run", n > 0, 1);
    check("glitch_retry_kept", bus.retry_cnt, 1);

    // Lock loss in RUN.
    bus.pll_locked = 0; tick();
    bus.pll_locked = 1; tick();
    check("loss_ready_before", bus.seq_ready, 1);
    tick();
    check("loss_ready_drop", bus.seq_ready, 0);
    check("loss_user_rst_n", bus.user_rst_n, 0);
    check("loss_count1", bus.lock_loss_cnt, 1);
    check("loss_retry_clear", bus.retry_cnt, 0);
    run_until(1, 1, 100, n);
    check("loss_resequence", n > 0, 1);
    bad = 0;
    for (int i = 0; i < 299; i++) begin
      bus.pll_locked = 0; tick();
      bus.pll_locked = 1;
      run_until(1, 0, 10, n);  if (n < 0) bad++;
      run_until(1, 1, 100, n); if (n < 0) bad++;
    end
    check("loss_loop_bounds", bad, 0);
    check("loss_saturated", bus.lock_loss_cnt, 255);

    // Asynchronous reset while in RUN.
    #2 rst_n = 0;
    #1;
    check("async_pll_rst",    bus.pll_rst, 1);
    check("async_user_rst_n", bus.user_rst_n, 0);
    check("async_seq_ready",  bus.seq_ready, 0);
    check("async_losses",     bus.lock_loss_cnt, 0);
    tick();
    rst_n = 1;

    // Randomized traffic.
    lk_left = 0; bt_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (lk_left == 0) begin
        bus.pll_locked = ($urandom_range(0, 3) != 0);
        lk_left = $urandom_range(1, 80);
      end
      lk_left--;
      if (bt_left == 0) begin
        bus.btn_in = 1'($urandom_range(0, 1));
        bt_left = $urandom_range(1, 20);
      end
      bt_left--;
      bus.restart_req = ($urandom_range(0, 149) == 0);
      tick();
    end
    bus.restart_req = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed 1 expected 0");
    $fatal(1, "simulation time limit");
  end

endmodule
